// File: rtl/c15xx_pkg.sv
// Shared stepper-phase definitions for the 1541/1571 head controller.
// The phase helpers decode one registered stepper transition into a direction.
package c15xx_pkg;

  localparam logic [1:0] PH_SEQ [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_IN   = 2'd1,
    STEP_OUT  = 2'd2
  } step_dir_t;

  function automatic logic [1:0] phase_pos(input logic [1:0] ph);
    logic [1:0] pos;
    pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (PH_SEQ[i] == ph) pos = 2'(i);
    end
    return pos;
  endfunction

  // One position forward in the rotation is a step in, one back is a step out;
  // a two-position jump is ambiguous and ignored.
  function automatic step_dir_t phase_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    step_dir_t  dir;
    delta = phase_pos(cur) - phase_pos(prev);
    case (delta)
      2'd1:    dir = STEP_IN;
      2'd3:    dir = STEP_OUT;
      default: dir = STEP_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/c15xx_stepper_dec.sv
// Stepper phase decoder: registers stp and emits one-cycle step pulses.
// While mtr is low the phase register still follows stp, so nothing is replayed later.
module c15xx_stepper_dec
  import c15xx_pkg::*;
(
  input  logic       clk_c1541,
  input  logic       reset,
  input  logic [1:0] stp,
  input  logic       mtr,
  output logic       step_in,
  output logic       step_out
);

  logic [1:0] stp_r;
  step_dir_t  dir;

  always_ff @(posedge clk_c1541) begin
    stp_r <= stp;
  end

  assign dir      = phase_step(stp_r, stp);
  assign step_in  = mtr & ~reset & (dir == STEP_IN);
  assign step_out = mtr & ~reset & (dir == STEP_OUT);

endmodule

// File: rtl/c15xx_head_ctrl.sv
// Head positioning, side select and dirty-track save handshake for 1541/1571.
// Also generates the disk-change write-protect flicker and the settled track_valid flag.
module c15xx_head_ctrl
  import c15xx_pkg::*;
#(
  parameter int HT_BITS       = 7,
  parameter int HT_MAX        = 80,
  parameter int HT_RESET      = 36,
  parameter int SIDES         = 1,
  parameter int SETTLE_CYCLES = 32000,
  parameter int CHG_CYCLES    = 15000000,
  parameter int CHG_BITS      = 24
) (
  input  logic               clk_c1541,
  input  logic               reset,
  input  logic [1:0]         stp,
  input  logic               mtr,
  input  logic               act,
  input  logic               side,
  input  logic               buff_we,
  input  logic               disk_change,
  input  logic               disk_readonly,
  output logic [HT_BITS-2:0] track_o,
  output logic               side_o,
  output logic               tr00_sense_n,
  output logic               wps_n,
  output logic               track_valid,
  output logic               save_req,
  output logic [HT_BITS-2:0] save_track,
  output logic               save_side,
  input  logic               save_ack,
  output logic               save_overrun
);

  localparam int SET_BITS = $clog2(SETTLE_CYCLES + 1);

  logic [HT_BITS-1:0]  ht;
  logic [HT_BITS-2:0]  cur_track;
  logic                step_in;
  logic                step_out;
  logic                side_sel;
  logic                side_r;
  logic                side_chg;
  logic                act_r;
  logic                act_fall;
  logic                leave;
  logic                dirty;
  logic                dirty_eff;
  logic [SET_BITS-1:0] settle_cnt;
  logic                dc_r;
  logic [CHG_BITS-1:0] chg_timer;
  logic                ch_state;

  c15xx_stepper_dec u_stepper_dec (
    .clk_c1541 (clk_c1541),
    .reset     (reset),
    .stp       (stp),
    .mtr       (mtr),
    .step_in   (step_in),
    .step_out  (step_out)
  );

  assign side_sel  = (SIDES == 2) ? side : 1'b0;
  assign cur_track = ht[HT_BITS-1:1];
  // side_o still holds the old side during the cycle the change is seen
  assign side_chg  = side_r ^ side_o;
  assign act_fall  = act_r & ~act;
  assign leave     = step_in | step_out | side_chg | act_fall;
  assign dirty_eff = dirty | buff_we;
  assign ch_state  = (chg_timer != '0);

  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      ht           <= HT_BITS'(HT_RESET);
      track_o      <= (HT_BITS-1)'(HT_RESET >> 1);
      tr00_sense_n <= ((HT_RESET >> 1) != 0);
      side_r       <= 1'b0;
      side_o       <= 1'b0;
      act_r        <= 1'b0;
    end else begin
      if (step_in)
        ht <= (ht >= HT_BITS'(HT_MAX)) ? HT_BITS'(HT_MAX) : ht + HT_BITS'(1);
      else if (step_out)
        ht <= (ht <= HT_BITS'(1)) ? HT_BITS'(1) : ht - HT_BITS'(1);
      track_o      <= cur_track;
      tr00_sense_n <= |cur_track;
      side_r       <= side_sel;
      side_o       <= side_r;
      act_r        <= act;
    end
  end

  // A write coinciding with a leave belongs to the track being left.
  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      dirty        <= 1'b0;
      save_req     <= 1'b0;
      save_track   <= '0;
      save_side    <= 1'b0;
      save_overrun <= 1'b0;
    end else if (disk_change) begin
      dirty    <= 1'b0;
      save_req <= 1'b0;
    end else begin
      if (save_req && save_ack) save_req <= 1'b0;
      if (leave) begin
        dirty <= 1'b0;
        if (dirty_eff) begin
          if (save_req) begin
            save_overrun <= 1'b1;
          end else begin
            save_req   <= 1'b1;
            save_track <= cur_track;
            save_side  <= side_o;
          end
        end
      end else if (buff_we) begin
        dirty <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_c1541) begin
    if (reset) begin
      settle_cnt  <= SET_BITS'(SETTLE_CYCLES);
      track_valid <= 1'b0;
      dc_r        <= 1'b0;
      chg_timer   <= '0;
      wps_n       <= ~disk_readonly;
    end else begin
      if (step_in || step_out || side_chg) begin
        settle_cnt  <= SET_BITS'(SETTLE_CYCLES);
        track_valid <= 1'b0;
      end else begin
        if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_BITS'(1);
        track_valid <= mtr && (settle_cnt == '0);
      end
      dc_r <= disk_change;
      if (disk_change && !dc_r)
        chg_timer <= CHG_BITS'(CHG_CYCLES);
      else if (ch_state)
        chg_timer <= chg_timer - CHG_BITS'(1);
      wps_n <= ~disk_readonly ^ ch_state;
    end
  end

endmodule

// File: tb/tb_c15xx_head_ctrl.sv
// Directed bench for c15xx_head_ctrl: a double-sided instance plus a single-sided
// twin on the same stimulus, checked one edge-plus-1ns after each clock.
module tb_c15xx_head_ctrl;

  localparam int S   = 20;
  localparam int CHG = 100;

  logic       clk_c1541 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] stp = 2'd0;
  logic       mtr = 1'b0, act = 1'b0, side = 1'b0, buff_we = 1'b0;
  logic       disk_change = 1'b0, disk_readonly = 1'b0, save_ack = 1'b0;

  logic [5:0] track_o, save_track, s1_track_o, s1_save_track;
  logic       side_o, tr00_sense_n, wps_n, track_valid, save_req, save_side, save_overrun;
  logic       s1_side_o, s1_tr00_sense_n, s1_wps_n, s1_track_valid, s1_save_req;
  logic       s1_save_side, s1_save_overrun;

  int checks = 0;
  int failures = 0;
  int idx = 0;
  logic [1:0] seq [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  always #5 clk_c1541 = ~clk_c1541;

  c15xx_head_ctrl #(.HT_BITS(7), .HT_MAX(80), .HT_RESET(36), .SIDES(2),
    .SETTLE_CYCLES(S), .CHG_CYCLES(CHG), .CHG_BITS(8)) u_dut (
    .clk_c1541(clk_c1541), .reset(reset), .stp(stp), .mtr(mtr), .act(act), .side(side),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .track_o(track_o), .side_o(side_o), .tr00_sense_n(tr00_sense_n), .wps_n(wps_n),
    .track_valid(track_valid), .save_req(save_req), .save_track(save_track),
    .save_side(save_side), .save_ack(save_ack), .save_overrun(save_overrun));

  c15xx_head_ctrl #(.HT_BITS(7), .HT_MAX(80), .HT_RESET(36), .SIDES(1),
    .SETTLE_CYCLES(S), .CHG_CYCLES(CHG), .CHG_BITS(8)) u_ss (
    .clk_c1541(clk_c1541), .reset(reset), .stp(stp), .mtr(mtr), .act(act), .side(side),
    .buff_we(buff_we), .disk_change(disk_change), .disk_readonly(disk_readonly),
    .track_o(s1_track_o), .side_o(s1_side_o), .tr00_sense_n(s1_tr00_sense_n), .wps_n(s1_wps_n),
    .track_valid(s1_track_valid), .save_req(s1_save_req), .save_track(s1_save_track),
    .save_side(s1_save_side), .save_ack(save_ack), .save_overrun(s1_save_overrun));

  task automatic tick();
    @(posedge clk_c1541);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic do_step(input bit dir_in, input int hold);
    idx = dir_in ? (idx + 1) % 4 : (idx + 3) % 4;
    stp = seq[idx];
    repeat (hold) tick();
  endtask

  task automatic pulse_we();
    buff_we = 1'b1;
    tick();
    buff_we = 1'b0;
  endtask

  task automatic pulse_ack();
    save_ack = 1'b1;
    tick();
    save_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (track_o !== 6'd18) begin failures++; $display("FAIL reset_track got=%0d exp=18", track_o); end
    checks++; if (tr00_sense_n !== 1'b1 || side_o !== 1'b0) begin failures++; $display("FAIL reset_tr00_side got=%b%b exp=10", tr00_sense_n, side_o); end
    checks++; if ({save_req, save_side, save_overrun, track_valid} !== 4'b0000 || save_track !== 6'd0) begin
      failures++; $display("FAIL reset_save got=%b%b%b%b trk=%0d exp=0000 trk=0", save_req, save_side, save_overrun, track_valid, save_track); end
    checks++; if (wps_n !== 1'b1) begin failures++; $display("FAIL reset_wps got=%b exp=1", wps_n); end
  endtask

  task automatic test_step_in();
    do_reset();
    mtr = 1'b1;
    repeat (3) do_step(1'b1, 10);
    do_step(1'b1, 1);
    repeat (S) tick();
    checks++; if (track_valid !== 1'b0) begin failures++; $display("FAIL settle_early got=%b exp=0", track_valid); end
    tick();
    checks++; if (track_valid !== 1'b1) begin failures++; $display("FAIL settle_rise got=%b exp=1", track_valid); end
    checks++; if (track_o !== 6'd20 || tr00_sense_n !== 1'b1) begin failures++; $display("FAIL step_in_track got=%0d/%b exp=20/1", track_o, tr00_sense_n); end
    stp = 2'd1; idx = 2;
    repeat (3) tick();
    stp = 2'd0; idx = 0;
    repeat (3) tick();
    checks++; if (track_o !== 6'd20 || track_valid !== 1'b1) begin failures++; $display("FAIL jump_ignored got=%0d/%b exp=20/1", track_o, track_valid); end
    mtr = 1'b0;
    do_step(1'b1, 3);
    do_step(1'b1, 3);
    checks++; if (track_o !== 6'd20 || track_valid !== 1'b0) begin failures++; $display("FAIL mtr_off got=%0d/%b exp=20/0", track_o, track_valid); end
    mtr = 1'b1;
  endtask

  task automatic test_step_out_sat();
    do_reset();
    mtr = 1'b1;
    repeat (40) do_step(1'b0, 2);
    checks++; if (track_o !== 6'd0 || tr00_sense_n !== 1'b0) begin failures++; $display("FAIL out_sat got=%0d/%b exp=0/0", track_o, tr00_sense_n); end
    do_step(1'b0, 2);
    do_step(1'b1, 2);
    checks++; if (track_o !== 6'd1 || tr00_sense_n !== 1'b1) begin failures++; $display("FAIL out_floor got=%0d/%b exp=1/1", track_o, tr00_sense_n); end
    repeat (90) do_step(1'b1, 2);
    checks++; if (track_o !== 6'd40) begin failures++; $display("FAIL in_sat got=%0d exp=40", track_o); end
    do_step(1'b0, 2);
    checks++; if (track_o !== 6'd39) begin failures++; $display("FAIL in_ceiling got=%0d exp=39", track_o); end
  endtask

  task automatic test_save();
    do_reset();
    mtr = 1'b1;
    tick();
    pulse_we();
    do_step(1'b1, 1);
    checks++; if (save_req !== 1'b1 || save_track !== 6'd18 || save_side !== 1'b0) begin
      failures++; $display("FAIL save_issue got=%b/%0d/%b exp=1/18/0", save_req, save_track, save_side); end
    repeat (50) tick();
    checks++; if (save_req !== 1'b1) begin failures++; $display("FAIL save_hold got=%b exp=1", save_req); end
    pulse_ack();
    checks++; if (save_req !== 1'b0) begin failures++; $display("FAIL save_ack_drop got=%b exp=0", save_req); end
    do_step(1'b1, 2);
    do_step(1'b1, 2);
    checks++; if (save_req !== 1'b0) begin failures++; $display("FAIL clean_leave got=%b exp=0", save_req); end
    buff_we = 1'b1;
    do_step(1'b1, 1);
    buff_we = 1'b0;
    checks++; if (save_req !== 1'b1 || save_track !== 6'd19) begin failures++; $display("FAIL we_on_leave got=%b/%0d exp=1/19", save_req, save_track); end
    pulse_ack();
    do_step(1'b1, 2);
    checks++; if (save_req !== 1'b0) begin failures++; $display("FAIL we_leave_clears got=%b exp=0", save_req); end
    act = 1'b1;
    tick();
    pulse_we();
    act = 1'b0;
    tick();
    checks++; if (save_req !== 1'b1 || save_track !== 6'd20) begin failures++; $display("FAIL act_fall got=%b/%0d exp=1/20", save_req, save_track); end
    pulse_ack();
  endtask

  task automatic test_overrun();
    pulse_we();
    do_step(1'b1, 1);
    pulse_we();
    do_step(1'b1, 2);
    checks++; if (save_track !== 6'd20 || save_overrun !== 1'b1 || track_o !== 6'd21) begin
      failures++; $display("FAIL overrun got=%0d/%b/%0d exp=20/1/21", save_track, save_overrun, track_o); end
    pulse_ack();
    tick();
    checks++; if (save_req !== 1'b0 || save_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b/%b exp=0/1", save_req, save_overrun); end
    pulse_we();
    do_step(1'b1, 1);
    do_reset();
    checks++; if (save_req !== 1'b0 || save_overrun !== 1'b0 || save_track !== 6'd0) begin
      failures++; $display("FAIL reset_mid_hs got=%b/%b/%0d exp=0/0/0", save_req, save_overrun, save_track); end
  endtask

  task automatic test_side();
    do_reset();
    mtr = 1'b1;
    side = 1'b0;
    repeat (S + 2) tick();
    checks++; if (track_valid !== 1'b1) begin failures++; $display("FAIL side_pre_valid got=%b exp=1", track_valid); end
    pulse_we();
    side = 1'b1;
    tick();
    tick();
    checks++; if (save_req !== 1'b1 || save_side !== 1'b0 || save_track !== 6'd18 || side_o !== 1'b1 || track_valid !== 1'b0) begin
      failures++; $display("FAIL side_leave got=%b/%b/%0d/%b/%b exp=1/0/18/1/0", save_req, save_side, save_track, side_o, track_valid); end
    checks++; if (s1_side_o !== 1'b0 || s1_save_req !== 1'b0 || s1_track_valid !== 1'b1) begin
      failures++; $display("FAIL single_side got=%b/%b/%b exp=0/0/1", s1_side_o, s1_save_req, s1_track_valid); end
    repeat (S) tick();
    checks++; if (track_valid !== 1'b0) begin failures++; $display("FAIL side_settle_early got=%b exp=0", track_valid); end
    tick();
    checks++; if (track_valid !== 1'b1) begin failures++; $display("FAIL side_settle_rise got=%b exp=1", track_valid); end
    side = 1'b0;
  endtask

  task automatic test_disk_change();
    int bad;
    do_reset();
    mtr = 1'b1;
    disk_readonly = 1'b0;
    pulse_we();
    do_step(1'b1, 1);
    pulse_we();
    disk_change = 1'b1;
    tick();
    disk_change = 1'b0;
    checks++; if (save_req !== 1'b0 || wps_n !== 1'b1) begin failures++; $display("FAIL chg_drop got=%b/%b exp=0/1", save_req, wps_n); end
    bad = 0;
    for (int i = 0; i < CHG; i++) begin
      tick();
      if (wps_n !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL chg_flicker high_cycles got=%0d exp=0", bad); end
    tick();
    checks++; if (wps_n !== 1'b1) begin failures++; $display("FAIL chg_end got=%b exp=1", wps_n); end
    do_step(1'b1, 2);
    checks++; if (save_req !== 1'b0) begin failures++; $display("FAIL chg_dirty_clear got=%b exp=0", save_req); end
    disk_readonly = 1'b1;
    tick();
    tick();
    checks++; if (wps_n !== 1'b0) begin failures++; $display("FAIL readonly got=%b exp=0", wps_n); end
    disk_readonly = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step_in();
    test_step_out_sat();
    test_save();
    test_overrun();
    test_side();
    test_disk_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/c15xx_head_ctrl.md
Name: c15xx_head_ctrl

Overview:
Parametrised head-positioning and track-dirty controller for the 1541/1571 drive family. It decodes stepper phases into a half-track position, tracks side selection for double-sided drives, and raises a req/ack save handshake whenever a modified track is left. It also generates the disk-change write-protect flicker and a settle-qualified track-valid flag. It sits between the drive logic (stp/mtr/act) and the GCR/track-buffer blocks in the drive top level.

Parameters:
HT_BITS, 7, half-track counter width
HT_MAX, 80, highest reachable half-track (saturating)
HT_RESET, 36, half-track loaded on reset (track 18)
SIDES, 1, 1 = single-sided (side input ignored, side_o = 0); 2 = double-sided
SETTLE_CYCLES, 32000, quiet cycles after last step before track_valid (1 ms at 32 MHz)
CHG_CYCLES, 15000000, write-protect flicker length after disk change
CHG_BITS, 24, change-timer width

Ports:
clk_c1541  in  1  drive clock, 32 MHz
reset  in  1  synchronous, active-high
stp  in  2  stepper phase from drive logic
mtr  in  1  spindle motor on; steps are ignored while low
act  in  1  drive activity; a falling edge forces a save check
side  in  1  head select (used only when SIDES=2)
buff_we  in  1  track-buffer write strobe; marks the current track dirty
disk_change  in  1  image change; level clears dirty, rising edge starts flicker
disk_readonly  in  1  image write-protected
track_o  out  HT_BITS-1  current whole track = half-track >> 1
side_o  out  1  current side
tr00_sense_n  out  1  low when track_o == 0
wps_n  out  1  write-protect sense to drive logic
track_valid  out  1  head settled on track_o/side_o
save_req  out  1  save request for save_track/save_side
save_track  out  HT_BITS-1  track to be written back
save_side  out  1  side to be written back
save_ack  in  1  one-cycle acknowledge from the track loader
save_overrun  out  1  sticky: a dirty track was lost while a save was pending

Behaviour:
- Reset values: half-track = HT_RESET; track_o = HT_RESET>>1; side_o = 0; dirty = 0; save_req = 0; save_track = 0; save_side = 0; save_overrun = 0; track_valid = 0; settle counter = SETTLE_CYCLES; change timer = 0; wps_n = ~disk_readonly.
- stp is registered once (stp_r). Phase order is 0→2→1→3→0. A transition one position forward in that order = step in; one position backward = step out; any other change, including a two-position jump, is ignored. Steps are decoded only while mtr = 1.
- Step in: half-track +1, saturating at HT_MAX. Step out: half-track −1, saturating at 1. A step blocked by saturation still counts as a leave event.
- track_o, side_o and tr00_sense_n are registered and lag the half-track counter by 1 cycle.
- Side change (SIDES=2): a change of the registered side value is a leave event and clears track_valid.
- Leave events are a step, a side change, or an act falling edge (act_r & ~act). If dirty = 1, the block latches the old track/side into save_track/save_side, sets save_req and clears dirty in the same cycle.
- buff_we sets dirty. If buff_we coincides with a leave event, the write belongs to the old track: the save is issued and dirty ends at 0.
- save_req stays high until a cycle with save_ack = 1, then drops the next cycle. save_ack while save_req = 0 is ignored.
- A dirty leave event while save_req = 1 does not change save_track/save_side and sets save_overrun. The step itself is still applied.
- disk_change = 1: dirty is cleared and save_req is dropped without ack. The pending save targets the old image.
- Rising edge of disk_change loads the change timer with CHG_CYCLES. While the timer is non-zero, ch_state = 1, otherwise 0. wps_n = ~disk_readonly ^ ch_state, registered.
- Settle: any step or side change reloads the settle counter and drops track_valid the next cycle. The counter decrements to 0; track_valid = 1 when it reaches 0 and mtr = 1. mtr = 0 holds track_valid at 0 but does not alter position.
- Reset mid-handshake: save_req is dropped and the pending save is discarded.

Decomposition:
- Package c15xx_pkg holds: the phase-order constants (PH_SEQ = {0,2,1,3}); the step_dir_t enum (STEP_NONE, STEP_IN, STEP_OUT); and a function phase_step(prev, cur) returning step_dir_t.
- Sub-module c15xx_stepper_dec: registers stp and emits one-cycle step_in/step_out pulses, gated by mtr.
- Save handshake, settle counter and change timer stay in the top-level block.

Test Plan:
- Reset, mtr = 1, stp 0→2→1→3→0 at 10-cycle spacing → half-track 40, track_o = 20, tr00_sense_n = 1, track_valid rises SETTLE_CYCLES+1 cycles after the last step.
- From reset, 40 step-outs → half-track saturates at 1, track_o = 0, tr00_sense_n = 0. A further step-out leaves it at 1.
- buff_we pulse on track 18, then one step in → save_req = 1, save_track = 18, save_side = 0. Hold save_ack low 50 cycles (save_req stays high), pulse save_ack → save_req = 0 next cycle.
- SIDES = 2, dirty on side 0 track 18, toggle side → save_req with save_side = 0, side_o = 1, track_valid low for the settle window.
- Dirty leave while save_req pending → save_track unchanged, save_overrun = 1 and stays set until reset.
- disk_readonly = 0, disk_change pulse with CHG_CYCLES = 100 → wps_n = 0 for 100 cycles then 1; a pending save_req drops with no ack; dirty = 0.
